// File: rtl/vend_if.sv
// Coin-decoder-to-vending-controller bundle: decoder inputs plus the
// controller's credit, dispense, change and reject outputs.
interface vend_if #(
    parameter int CREDIT_W = 6
);
    logic                pressed_i;
    logic [4:0]          value_i;
    logic                cancel_i;
    logic [CREDIT_W-1:0] credit_o;
    logic                soda_o;
    logic [4:0]          change_o;
    logic                change_valid_o;
    logic                reject_o;

    modport master (
        output pressed_i, value_i, cancel_i,
        input  credit_o, soda_o, change_o, change_valid_o, reject_o
    );

    modport slave (
        input  pressed_i, value_i, cancel_i,
        output credit_o, soda_o, change_o, change_valid_o, reject_o
    );
endinterface

// File: rtl/vend_controller.sv
// Credit-accumulating vending FSM: sums coins, dispenses with change, refunds on cancel.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle cycles in COLLECT.
module vend_controller #(
    parameter int PRICE       = 20,
    parameter int CREDIT_W    = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic  clk_i,
    input  logic  rst_i,
    vend_if.slave bus
);

    if (PRICE % 5 != 0 || PRICE < 5 || PRICE + 20 > (1 << CREDIT_W) - 1) begin : g_bad_price
        $error("vend_controller: PRICE does not fit the credit register");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("vend_controller: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_REFUND
    } state_e;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [4:0]          change_q, change_d;
    logic                reject_q, reject_d;
    logic                pressed_q;

    logic                coin_edge;
    logic [CREDIT_W-1:0] sum;

    assign coin_edge = bus.pressed_i & ~pressed_q;
    assign sum       = credit_q + CREDIT_W'(bus.value_i);

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            credit_q  <= '0;
            change_q  <= '0;
            reject_q  <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            change_q  <= change_d;
            reject_q  <= reject_d;
            pressed_q <= bus.pressed_i;
        end
    end

    // NOTE: every next-state signal gets a default before the case so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = '0;
        reject_d = 1'b0;
`ifdef VEND_TIMEOUT_EN
        cnt_d    = '0;
`endif
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (coin_edge && bus.value_i == 5'd0) begin
                    reject_d = 1'b1;
`ifdef VEND_TIMEOUT_EN
                    // A rejected coin is not activity; keep the idle count running.
                    if (state_q == S_COLLECT)
                        cnt_d = (cnt_q >= CNT_LIM) ? cnt_q : cnt_q + 1'b1;
`endif
                end else if (coin_edge) begin
                    credit_d = sum;
                    if (sum >= PRICE_C) begin
                        state_d  = S_VEND;
                        change_d = 5'(sum - PRICE_C);
                    end else if (bus.cancel_i) begin
                        state_d  = S_REFUND;
                        change_d = 5'(sum);
                    end else begin
                        state_d  = S_COLLECT;
                    end
                end else if (state_q == S_COLLECT && bus.cancel_i) begin
                    state_d  = S_REFUND;
                    change_d = 5'(credit_q);
                end
`ifdef VEND_TIMEOUT_EN
                else if (state_q == S_COLLECT) begin
                    if (cnt_q >= CNT_LIM) begin
                        state_d  = S_REFUND;
                        change_d = 5'(credit_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            S_VEND, S_REFUND: begin
                // Coins arriving while paying out are refused, not queued.
                state_d  = S_IDLE;
                credit_d = '0;
                reject_d = coin_edge;
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign bus.credit_o       = credit_q;
    assign bus.soda_o         = (state_q == S_VEND);
    assign bus.change_valid_o = (state_q == S_VEND) || (state_q == S_REFUND);
    assign bus.change_o       = change_q;
    assign bus.reject_o       = reject_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios with fixed
// expectations plus randomized traffic against a credit-level reference model.
module tb_vend_controller;

    localparam int CW    = 6;
    localparam int PRICE = 20;
    localparam int TO    = 8;

    typedef logic [CW+7:0] vec_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    vend_if #(.CREDIT_W(CW)) bus ();

    vend_controller #(
        .PRICE      (PRICE),
        .CREDIT_W   (CW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a credit total, a "paying out" flag and the pulses due next cycle.
    int         m_credit = 0;
    int         m_idle   = 0;
    bit         m_busy   = 0;
    bit         m_prev   = 0;
    bit         e_soda   = 0;
    bit         e_cv     = 0;
    bit         e_rej    = 0;
    logic [4:0] e_change = '0;

    function automatic vec_t mk(input int cr, input bit s, input int ch, input bit cv, input bit rj);
        return {CW'(cr), s, 5'(ch), cv, rj};
    endfunction

    function automatic vec_t obs();
        return {bus.credit_o, bus.soda_o, bus.change_o, bus.change_valid_o, bus.reject_o};
    endfunction

    function automatic vec_t model_vec();
        return {CW'(m_credit), e_soda, e_change, e_cv, e_rej};
    endfunction

    task automatic payout(input int amount, input bit vend);
        m_busy   = 1;
        m_idle   = 0;
        e_cv     = 1;
        e_soda   = vend;
        e_change = 5'(amount);
    endtask

    task automatic model_step(input bit r, input bit p, input int v, input bit c);
        bit edge_seen;
        int s;
        e_soda = 0; e_cv = 0; e_rej = 0; e_change = '0;
        if (r) begin
            m_prev = 0; m_credit = 0; m_busy = 0; m_idle = 0;
            return;
        end
        edge_seen = p && !m_prev;
        m_prev    = p;
        if (m_busy) begin
            m_busy   = 0;
            m_credit = 0;
            e_rej    = edge_seen;
        end else if (edge_seen && v == 0) begin
            e_rej = 1;
            if (m_credit > 0 && m_idle < TO - 1) m_idle++;
        end else if (edge_seen) begin
            s        = m_credit + v;
            m_credit = s;
            m_idle   = 0;
            if (s >= PRICE) payout(s - PRICE, 1);
            else if (c)     payout(s, 0);
        end else if (m_credit > 0 && c) begin
            payout(m_credit, 0);
        end else if (m_credit > 0) begin
`ifdef VEND_TIMEOUT_EN
            if (m_idle >= TO - 1) payout(m_credit, 0);
            else                  m_idle++;
`endif
        end
    endtask

    task automatic tick(input bit r, input bit p, input int v, input bit c);
        @(negedge clk);
        rst           = r;
        bus.pressed_i = p;
        bus.value_i   = 5'(v);
        bus.cancel_i  = c;
        @(posedge clk);
        model_step(r, p, v, c);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        total++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_idle: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
        tick(1, 1, 25, 1);
        total++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_busy_inputs: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_quarter();
        tick(0, 1, 25, 0);
        total++;
        if (obs() !== mk(25, 1, 5, 1, 0)) begin
            bad++; $display("FAIL quarter_vend: got %h want %h", obs(), mk(25, 1, 5, 1, 0));
        end
        for (int i = 0; i < 2; i++) begin
            tick(0, 1, 25, 0);
            total++;
            if (obs() !== mk(0, 0, 0, 0, 0)) begin
                bad++; $display("FAIL quarter_held: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
            end
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_nickels();
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1, 5, 0);
            tick(0, 0, 0, 0);
            total++;
            if (obs() !== mk(5 * i, 0, 0, 0, 0)) begin
                bad++; $display("FAIL nickel_step: got %h want %h", obs(), mk(5 * i, 0, 0, 0, 0));
            end
        end
        tick(0, 1, 5, 0);
        total++;
        if (obs() !== mk(20, 1, 0, 1, 0)) begin
            bad++; $display("FAIL nickel_exact_vend: got %h want %h", obs(), mk(20, 1, 0, 1, 0));
        end
        tick(0, 0, 0, 0);
        total++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL nickel_after_vend: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_dime_quarter();
        tick(0, 1, 10, 0);
        tick(0, 0, 0, 0);
        total++;
        if (obs() !== mk(10, 0, 0, 0, 0)) begin
            bad++; $display("FAIL dime_credit: got %h want %h", obs(), mk(10, 0, 0, 0, 0));
        end
        tick(0, 1, 25, 0);
        total++;
        if (obs() !== mk(35, 1, 15, 1, 0)) begin
            bad++; $display("FAIL dime_quarter_vend: got %h want %h", obs(), mk(35, 1, 15, 1, 0));
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_cancel();
        tick(0, 1, 10, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        total++;
        if (obs() !== mk(10, 0, 10, 1, 0)) begin
            bad++; $display("FAIL cancel_refund: got %h want %h", obs(), mk(10, 0, 10, 1, 0));
        end
        tick(0, 1, 10, 1);
        total++;
        if (obs() !== mk(0, 0, 0, 0, 1)) begin
            bad++; $display("FAIL coin_in_refund: got %h want %h", obs(), mk(0, 0, 0, 0, 1));
        end
        tick(0, 1, 10, 1);
        total++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL cancel_in_idle: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_reject();
        tick(0, 1, 10, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        total++;
        if (obs() !== mk(10, 0, 0, 0, 1)) begin
            bad++; $display("FAIL invalid_reject: got %h want %h", obs(), mk(10, 0, 0, 0, 1));
        end
        tick(0, 1, 0, 0);
        total++;
        if (obs() !== mk(10, 0, 0, 0, 0)) begin
            bad++; $display("FAIL invalid_held: got %h want %h", obs(), mk(10, 0, 0, 0, 0));
        end
        tick(0, 0, 0, 0);
        tick(0, 1, 5, 1);
        total++;
        if (obs() !== mk(15, 0, 15, 1, 0)) begin
            bad++; $display("FAIL coin_cancel_refund: got %h want %h", obs(), mk(15, 0, 15, 1, 0));
        end
        tick(0, 0, 0, 0);
        tick(0, 1, 10, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 10, 1);
        total++;
        if (obs() !== mk(20, 1, 0, 1, 0)) begin
            bad++; $display("FAIL coin_cancel_vend: got %h want %h", obs(), mk(20, 1, 0, 1, 0));
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        tick(0, 1, 25, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 10, 0);
        total++;
        if (obs() !== mk(10, 0, 0, 0, 0)) begin
            bad++; $display("FAIL back_to_back_coin: got %h want %h", obs(), mk(10, 0, 0, 0, 0));
        end
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 5, 0);
            tick(0, 0, 0, 0);
        end
        tick(1, 1, 5, 0);
        total++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_discard: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
        tick(0, 1, 5, 0);
        total++;
        if (obs() !== mk(5, 0, 0, 0, 0)) begin
            bad++; $display("FAIL held_across_reset: got %h want %h", obs(), mk(5, 0, 0, 0, 0));
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        // Starts with credit 5 left over from the previous scenario.
`ifdef VEND_TIMEOUT_EN
        for (int i = 0; i < TO - 2; i++) tick(0, 0, 0, 0);
        total++;
        if (obs() !== mk(5, 0, 0, 0, 0)) begin
            bad++; $display("FAIL timeout_early: got %h want %h", obs(), mk(5, 0, 0, 0, 0));
        end
        tick(0, 0, 0, 0);
        total++;
        if (obs() !== mk(5, 0, 5, 1, 0)) begin
            bad++; $display("FAIL timeout_refund: got %h want %h", obs(), mk(5, 0, 5, 1, 0));
        end
        tick(0, 0, 0, 0);
`else
        for (int i = 0; i < 3 * TO; i++) tick(0, 0, 0, 0);
        total++;
        if (obs() !== mk(5, 0, 0, 0, 0)) begin
            bad++; $display("FAIL credit_held: got %h want %h", obs(), mk(5, 0, 0, 0, 0));
        end
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
`endif
    endtask

    task automatic test_random();
        bit p = 0;
        int coins [4] = '{0, 5, 10, 25};
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) p = !p;
            tick($urandom_range(0, 99) == 0, p, coins[$urandom_range(0, 3)],
                 $urandom_range(0, 9) == 0);
            total++;
            if (obs() !== model_vec()) begin
                bad++; $display("FAIL random_cycle_%0d: got %h want %h", i, obs(), model_vec());
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.pressed_i = 1'b0;
        bus.value_i   = '0;
        bus.cancel_i  = 1'b0;
        test_reset();
        test_quarter();
        test_nickels();
        test_dime_quarter();
        test_cancel();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
